// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the async-FIFO read-side stream adapter.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_FLUSHED = 2'd2
   } rd_state_t;

   localparam int BUF_DEPTH = 3;
   localparam int PKT_CNT_W = 16;
   localparam int BEAT_W    = 16;

   // Circular pointer step over the 3-entry buffer.
   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'(BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular buffer between the FIFO read port and the output stream.
module fifo_rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  rclk,
   input  logic                  sw_rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            occ
);

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop  = pop && (occ != 2'd0);
   assign do_push = push && ((occ != 2'(BUF_DEPTH)) || do_pop);

   // NOTE: storage needs no reset; occ gates every read, so stale entries are never visible.
   always_ff @(posedge rclk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge rclk) begin
      if (sw_rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         occ    <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign head = (occ != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains the async FIFO read port into a framed valid/ready stream with flush handshake.
// Optional statistics outputs are enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream_adapter
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int PKT_LEN       = 8
) (
   input  logic                   rclk,
   input  logic                   sw_rst,
   output logic                   read_enable,
   input  logic [DATA_WIDTH-1:0]  read_data,
   input  logic                   rdempty,
   input  logic [ADDRESS_WIDTH:0] rd_level,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_last,
   input  logic                   flush_req,
   output logic                   flush_done,
   output logic [PKT_CNT_W-1:0]   pkt_count
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [31:0]            starve_cycles,
   output logic [ADDRESS_WIDTH:0] max_rd_level
`endif
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   rd_state_t         state;
   logic              inflight;
   logic [1:0]        occ;
   logic [2:0]        fill;
   logic [BEAT_W-1:0] beat_idx;
   logic              pop;

   // Words held plus the one still in flight must never exceed the buffer.
   assign fill        = {1'b0, occ} + {2'b00, inflight};
   assign read_enable = (state == ST_RUN) && !flush_req && !rdempty &&
                        (fill < 3'(BUF_DEPTH));

   assign m_valid = (occ != 2'd0);
   assign m_last  = m_valid && (beat_idx == LAST_BEAT);
   assign pop     = m_valid && m_ready;

   fifo_rd_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_buf (
      .rclk      (rclk),
      .sw_rst    (sw_rst),
      .push      (inflight),
      .push_data (read_data),
      .pop       (pop),
      .head      (m_data),
      .occ       (occ)
   );

   // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge rclk) begin
      if (sw_rst) begin
         state      <= ST_RUN;
         flush_done <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (flush_req) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!flush_req) begin
                  state <= ST_RUN;
               end else if ((occ == 2'd0) && !inflight) begin
                  state      <= ST_FLUSHED;
                  flush_done <= 1'b1;
               end
            end
            ST_FLUSHED: begin
               if (!flush_req) begin
                  state      <= ST_RUN;
                  flush_done <= 1'b0;
               end
            end
            default: begin
               state      <= ST_RUN;
               flush_done <= 1'b0;
            end
         endcase
      end
   end

   // Packet framing survives a flush so a partial packet resumes where it stopped.
   always_ff @(posedge rclk) begin
      if (sw_rst) begin
         inflight  <= 1'b0;
         beat_idx  <= '0;
         pkt_count <= '0;
      end else begin
         inflight <= read_enable;
         if (pop) begin
            if (m_last) begin
               beat_idx  <= '0;
               pkt_count <= pkt_count + PKT_CNT_W'(1);
            end else begin
               beat_idx <= beat_idx + BEAT_W'(1);
            end
         end
      end
   end

`ifdef FIFO_RD_STATS_EN
   always_ff @(posedge rclk) begin
      if (sw_rst) begin
         stall_cycles  <= '0;
         starve_cycles <= '0;
         max_rd_level  <= '0;
      end else begin
         if (m_valid && !m_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
         if ((state == ST_RUN) && rdempty && (occ == 2'd0) && (starve_cycles != '1))
            starve_cycles <= starve_cycles + 32'd1;
         if (rd_level > max_rd_level)
            max_rd_level <= rd_level;
      end
   end
`else
   logic unused_rd_level;
   assign unused_rd_level = ^rd_level;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench: FIFO read-port model, stream scoreboard, directed tables and random traffic.
module tb_fifo_rd_stream_adapter;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int PKT = 5;

   logic          rclk = 1'b0;
   logic          sw_rst = 1'b0;
   logic          read_enable;
   logic [DW-1:0] read_data = '0;
   logic          rdempty = 1'b1;
   logic [AW:0]   rd_level = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          flush_req = 1'b0;
   logic          flush_done;
   logic [15:0]   pkt_count;
`ifdef FIFO_RD_STATS_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   starve_cycles;
   logic [AW:0]   max_rd_level;
`endif

   fifo_rd_stream_adapter #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .PKT_LEN(PKT)
   ) dut (
      .rclk        (rclk),
      .sw_rst      (sw_rst),
      .read_enable (read_enable),
      .read_data   (read_data),
      .rdempty     (rdempty),
      .rd_level    (rd_level),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .pkt_count   (pkt_count)
`ifdef FIFO_RD_STATS_EN
      ,
      .stall_cycles  (stall_cycles),
      .starve_cycles (starve_cycles),
      .max_rd_level  (max_rd_level)
`endif
   );

   initial forever #5 rclk = ~rclk;

   int n_vec = 0;
   int n_err = 0;

   // FIFO model and stream scoreboard
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            acc = 0;
   int            empty_reads = 0;
   int            cyc = 0;
   logic          re_pend = 1'b0;
   logic          hold_pending = 1'b0;
   logic [DW-1:0] hold_data = '0;
   logic          hold_last = 1'b0;

   typedef struct {
      logic          m_ready;
      logic          exp_re;
      logic          exp_mv;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t stall_tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic update_flags();
      rdempty  = (fifo_q.size() == 0);
      rd_level = (AW+1)'(fifo_q.size());
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      update_flags();
   endtask

   task automatic monitor();
      logic [DW-1:0] w;
      if (hold_pending) begin
         check("hold_valid", 32'(m_valid), 32'd1);
         check("hold_data", m_data, hold_data);
         check("hold_last", 32'(m_last), 32'(hold_last));
      end
      if (m_valid && m_ready) begin
         check("pkt_count_run", 32'(pkt_count), 32'((acc / PKT) % 65536));
         check("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("stream_data", m_data, w);
         end
         check("stream_last", 32'(m_last), 32'((acc % PKT) == PKT - 1));
         acc++;
      end else if (!m_valid) begin
         check("idle_last", 32'(m_last), 32'd0);
      end
      hold_pending = m_valid && !m_ready;
      hold_data    = m_data;
      hold_last    = m_last;
   endtask

   task automatic sample();
      @(negedge rclk);
      cyc++;
      if (read_enable && rdempty) empty_reads++;
      if (!sw_rst) monitor();
      re_pend = read_enable;
   endtask

   // FIFO read port: data appears the cycle after the strobe.
   task automatic advance();
      @(posedge rclk);
      #1;
      if (re_pend) begin
         check("fifo_nonempty_on_read", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) read_data = fifo_q.pop_front();
      end
      re_pend = 1'b0;
      update_flags();
   endtask

   task automatic do_reset();
      sw_rst       = 1'b1;
      m_ready      = 1'b0;
      flush_req    = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      acc          = 0;
      hold_pending = 1'b0;
      update_flags();
      sample();
      advance();
      sw_rst = 1'b0;
   endtask

   initial begin
      int re_cnt, re_first, re_last, ac_first, ac_last, prev_acc, n;

      // stall table: 6 words 100..105, downstream blocked then released
      stall_tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'd0};
      stall_tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'd0};
      stall_tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd100};
      stall_tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'd100};
      stall_tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'd100};
      stall_tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'd100};
      stall_tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'd100};
      stall_tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'd101};
      stall_tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'd102};
      stall_tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'd103};
      stall_tbl[10] = '{1'b1, 1'b0, 1'b1, 32'd104};
      stall_tbl[11] = '{1'b1, 1'b0, 1'b1, 32'd105};
      stall_tbl[12] = '{1'b1, 1'b0, 1'b0, 32'd0};

      // reset state
      do_reset();
      sample();
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_m_data", m_data, 32'd0);
      check("rst_flush_done", 32'(flush_done), 32'd0);
      check("rst_read_enable", 32'(read_enable), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      advance();

      // back-to-back 16 words
      do_reset();
      for (int i = 0; i < 16; i++) push_word(32'(i));
      m_ready = 1'b1;
      re_cnt = 0; re_first = -1; re_last = -1; ac_first = -1; ac_last = -1;
      n = 0;
      while (acc < 16 && n < 60) begin
         prev_acc = acc;
         sample();
         if (read_enable) begin
            re_cnt++;
            if (re_first < 0) re_first = cyc;
            re_last = cyc;
         end
         if (acc != prev_acc) begin
            if (ac_first < 0) ac_first = cyc;
            ac_last = cyc;
         end
         advance();
         n++;
      end
      check("b2b_words", 32'(acc), 32'd16);
      check("b2b_re_count", 32'(re_cnt), 32'd16);
      check("b2b_re_span", 32'(re_last - re_first + 1), 32'd16);
      check("b2b_beat_span", 32'(ac_last - ac_first + 1), 32'd16);
      check("b2b_latency", 32'(ac_first - re_first), 32'd2);
      check("b2b_pkt_count", 32'(pkt_count), 32'd3);

      // backpressure table
      do_reset();
      for (int i = 0; i < 6; i++) push_word(32'(100 + i));
      for (int i = 0; i < 13; i++) begin
         m_ready = stall_tbl[i].m_ready;
         sample();
         check($sformatf("tbl%0d_read_enable", i), 32'(read_enable), 32'(stall_tbl[i].exp_re));
         check($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(stall_tbl[i].exp_mv));
         if (stall_tbl[i].exp_mv) check($sformatf("tbl%0d_m_data", i), m_data, stall_tbl[i].exp_data);
         advance();
      end
      check("tbl_all_delivered", 32'(acc), 32'd6);

      // empty FIFO: nothing fetched, nothing presented
      do_reset();
      m_ready = 1'b1;
      re_cnt = 0; n = 0;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (read_enable) re_cnt++;
         if (m_valid) n++;
         advance();
      end
      check("empty_no_read", 32'(re_cnt), 32'd0);
      check("empty_no_valid", 32'(n), 32'd0);

      // flush after word 3, then resume
      do_reset();
      for (int i = 0; i < 20; i++) push_word(32'(200 + i));
      m_ready = 1'b1;
      n = 0;
      while (acc < 4 && n < 30) begin sample(); advance(); n++; end
      check("flush_pre_words", 32'(acc), 32'd4);
      flush_req = 1'b1;
      sample();
      check("flush_re_drop", 32'(read_enable), 32'd0);
      advance();
      re_cnt = 0; n = 0;
      while (!flush_done && n < 20) begin
         sample();
         if (read_enable) re_cnt++;
         advance();
         n++;
      end
      check("flush_done_set", 32'(flush_done), 32'd1);
      check("flush_no_fetch", 32'(re_cnt), 32'd0);
      check("flush_drained_valid", 32'(m_valid), 32'd0);
      check("flush_nothing_lost", 32'(exp_q.size()), 32'(fifo_q.size()));
      for (int i = 0; i < 3; i++) begin sample(); advance(); end
      check("flush_done_held", 32'(flush_done), 32'd1);
      flush_req = 1'b0;
      n = 0;
      while (acc < 20 && n < 60) begin sample(); advance(); n++; end
      check("flush_resume_words", 32'(acc), 32'd20);
      check("flush_resume_pkts", 32'(pkt_count), 32'd4);
      check("flush_done_clear", 32'(flush_done), 32'd0);

      // reset mid-packet with two words buffered
      do_reset();
      for (int i = 0; i < 4; i++) push_word(32'(300 + i));
      m_ready = 1'b1;
      n = 0;
      while (acc < 2 && n < 20) begin sample(); advance(); n++; end
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin sample(); advance(); end
      check("pre_rst_valid", 32'(m_valid), 32'd1);
      do_reset();
      sample();
      check("midrst_m_valid", 32'(m_valid), 32'd0);
      check("midrst_pkt_count", 32'(pkt_count), 32'd0);
      check("midrst_read_enable", 32'(read_enable), 32'd0);
      check("midrst_m_last", 32'(m_last), 32'd0);
      advance();
      for (int i = 0; i < 5; i++) push_word(32'(400 + i));
      m_ready = 1'b1;
      n = 0;
      while (acc < 5 && n < 30) begin sample(); advance(); n++; end
      check("midrst_new_pkt", 32'(pkt_count), 32'd1);

      // random backpressure and producer, 1000 words
      do_reset();
      n = 0; prev_acc = 0;
      while (acc < 1000 && n < 20000) begin
         m_ready = 1'($urandom % 2);
         if (prev_acc < 1000 && fifo_q.size() < 32 && ($urandom % 4) != 0) begin
            push_word($urandom);
            prev_acc++;
         end
         sample();
         advance();
         n++;
      end
      check("rand_words", 32'(acc), 32'd1000);
      check("rand_pkt_count", 32'(pkt_count), 32'd200);
      check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

      check("no_read_when_empty", 32'(empty_reads), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
